clb_cfg_loader: RTL and testbench
=================================

// Module: clb_cfg_loader
// PURPOSE
//  Serial configuration loader directly upstream of the clb array. Takes the
//  bitstream one bit at a time, checks framing and parity, and writes one
//  37-bit config word per CLB through a parallel write port. Each CLB latches
//  its mux selects, LUT mem, comboption, o2m/DQmux bits and floporlatch on CFG_WE.
// PARAMETERS
//  CFG_W    37   config bits per CLB frame
//  NUM_CLB  4    frames per bitstream; CLB addresses 0..NUM_CLB-1
//  ADDR_W   2    CFG_ADDR width, >= clog2(NUM_CLB)
//  PRE      4'b0010  preamble; last 4 bits received, oldest bit in MSB
// PORTS
//  K         in   1       clock, rising edge
//  RST       in   1       async reset, active-high
//  DIN       in   1       serial bitstream; line idles at 1
//  DIN_VALID in   1       DIN sampled only on edges where this is 1
//  START     in   1       restart from IDLE; clears DONE. Ignored while BUSY=1
//  CFG_WE    out  1       one-cycle write strobe to CLB CFG_ADDR
//  CFG_ADDR  out  ADDR_W  target CLB index
//  CFG_DATA  out  CFG_W   config word, field map below
//  BUSY      out  1       1 in PRE, FRAME, CHECK states
//  DONE      out  1       all NUM_CLB frames written
//  ERR       out  1       sticky framing/parity error
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, the bit counter and the frame counter = 0.
//   Reset asserted mid-frame drops the partial word; no CFG_WE is issued.
//  CFG_DATA field map, MSB first:
//   [36:35] mux2select  [34:33] mux3select  [32:31] mux4select
//   [30:29] mux5select  [28:27] mux6select  [26:11] mem[15:0]
//   [10:9] comboption   [8:3] o2m1_0,o2m2_0,o2m3_0,o2m1_1,o2m2_1,o2m3_1
//   [2:1] DQmux1,DQmux2 [0] floporlatch
//  Frame (40 valid bits): start bit 0; CFG_W data bits MSB first; parity bit;
//   stop bit 1. Parity is even: XOR of the data bits and the parity bit = 0.
//  FSM (advances only on DIN_VALID=1, except CHECK):
//   IDLE : 4-bit shift register tracks DIN. Register==PRE -> PRE state,
//          BUSY=1, frame counter=0.
//   PRE  : DIN=0 -> FRAME (this bit is the start bit). DIN=1 -> stay (idle fill).
//   FRAME: shift CFG_W data bits, then the parity bit, then the stop bit.
//          After the stop bit -> CHECK.
//   CHECK: one cycle, no DIN consumed. Parity ok and stop=1: CFG_WE=1,
//          CFG_ADDR=frame counter, CFG_DATA=word. Then last frame -> DONE,
//          else increment counter -> PRE. Parity bad or stop=0: ERR=1 -> ERRS,
//          no CFG_WE.
//   DONE : DONE=1, BUSY=0. START -> IDLE, DONE=0.
//   ERRS : ERR=1, BUSY=0. Only RST clears ERR.
//  Latency: CFG_WE rises on the edge after the edge that samples the stop bit.
//  CFG_DATA/CFG_ADDR hold their last written value between strobes.
//  DIN_VALID=0 holds every state except CHECK (CHECK always exits after 1 cycle).
//  START in IDLE: no effect. START in ERRS: ignored.
//  START and RST together: RST wins.
// TESTING
//  1 RST, idle 1s, PRE, 4 frames of 37'h1_5000_8B038 with parity 0 -> four
//    CFG_WE pulses, addr 0,1,2,3, then DONE=1, BUSY=0, ERR=0.
//  2 Frame 1 with the parity bit flipped -> ERR=1 one cycle after its stop
//    bit; only addr 0 written; later bits ignored; DONE stays 0.
//  3 Stop bit 0 in frame 0 -> ERR=1, no CFG_WE at all.
//  4 Random DIN_VALID gaps (~50% duty) in scenario 1 -> same writes and data;
//    exactly 4 CFG_WE pulses, each 1 cycle wide.
//  5 RST pulsed at bit 20 of frame 2 -> all outputs 0 immediately; new
//    bitstream loads cleanly from addr 0.
//  6 DONE, START=1 for 1 cycle, second bitstream -> DONE=0, then 4 writes
//    with the new data, DONE=1 again.

Source files
------------

// File: rtl/clb_cfg_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clb_cfg_loader
//
// Serial configuration loader that sits directly upstream of the CLB array.
// A bitstream arrives one bit per qualified clock edge. The loader hunts for
// a 4-bit preamble, then receives NUM_CLB frames. Each frame carries one
// CFG_W-bit configuration word, an even-parity bit and a stop bit. Every
// frame that passes its checks is presented to the array as a single-cycle
// write strobe with its target CLB index and the word itself.
//
// Frame on the wire (only DIN_VALID=1 edges count):
//   start(0) | CFG_W data bits, MSB first | parity | stop(1)
//   Parity is even: XOR over the data bits and the parity bit is 0.
//
// Config word layout presented on CFG_DATA (MSB first):
//   [36:35] mux2select  [34:33] mux3select  [32:31] mux4select
//   [30:29] mux5select  [28:27] mux6select  [26:11] mem[15:0]
//   [10:9]  comboption  [8:3]   o2m1_0,o2m2_0,o2m3_0,o2m1_1,o2m2_1,o2m3_1
//   [2:1]   DQmux1,DQmux2       [0] floporlatch
//
// Ports
//   K          in   clock, rising edge
//   RST        in   asynchronous reset, active-high
//   DIN        in   serial bitstream, idles at 1
//   DIN_VALID  in   qualifies DIN on the current edge
//   START      in   return from DONE to IDLE for another bitstream
//   CFG_WE     out  one-cycle write strobe towards CLB CFG_ADDR
//   CFG_ADDR   out  target CLB index, holds between strobes
//   CFG_DATA   out  config word, holds between strobes
//   BUSY       out  high while a bitstream is in progress
//   DONE       out  all NUM_CLB frames written
//   ERR        out  sticky framing/parity error, cleared only by RST
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int         CFG_W   = 37,
    parameter int         NUM_CLB = 4,
    parameter int         ADDR_W  = 2,
    parameter logic [3:0] PRE     = 4'b0010
) (
    input  logic              K,
    input  logic              RST,
    input  logic              DIN,
    input  logic              DIN_VALID,
    input  logic              START,
    output logic              CFG_WE,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [CFG_W-1:0]  CFG_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    // Bit counter indexes the bits after the start bit:
    // 0..CFG_W-1 data, CFG_W parity, CFG_W+1 stop.
    localparam int                BCNT_W    = $clog2(CFG_W + 2);
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(CFG_W - 1);
    localparam logic [BCNT_W-1:0] STOP_IDX  = BCNT_W'(CFG_W + 1);
    localparam logic [ADDR_W-1:0] LAST_CLB  = ADDR_W'(NUM_CLB - 1);

    // An idle line is all ones; starting the hunt register from ones keeps a
    // short 1,0 pattern after reset from being mistaken for the preamble.
    localparam logic [3:0]        HUNT_INIT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_FRAME,
        S_CHECK,
        S_DONE,
        S_ERRS
    } state_t;

    state_t              state;
    logic [3:0]          pre_sh;
    logic [3:0]          pre_next;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]   frame_cnt;
    logic                par_acc;
    logic                stop_bit;
    logic [CFG_W-1:0]    word_sh;
    logic                shift_data;

    // A frame is accepted only when parity balances and the stop bit is 1.
    function automatic logic frame_ok(input logic par, input logic stop);
        return (par == 1'b0) && (stop == 1'b1);
    endfunction

    // Preamble hunt: the comparison includes the bit being sampled now, so
    // the FSM leaves IDLE on the same edge that completes the preamble.
    assign pre_next = {pre_sh[2:0], DIN};

    // Data bits are shifted in only while the counter is inside the data
    // field; parity and stop bits never enter the word.
    assign shift_data = (state == S_FRAME) && DIN_VALID && (bit_cnt <= LAST_DATA);

    // Word assembly register: pure datapath, no reset. A frame interrupted
    // by RST leaves stale bits here, but they can never be strobed out
    // because the FSM restarts in IDLE and must receive a whole new frame.
    always_ff @(posedge K) begin
        if (shift_data) begin
            word_sh <= {word_sh[CFG_W-2:0], DIN};
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pre_sh    <= HUNT_INIT;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            par_acc   <= 1'b0;
            stop_bit  <= 1'b0;
            CFG_WE    <= 1'b0;
            CFG_ADDR  <= '0;
            CFG_DATA  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse; only CHECK raises it.
            CFG_WE <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (DIN_VALID) begin
                        pre_sh <= pre_next;
                        if (pre_next == PRE) begin
                            state     <= S_PRE;
                            BUSY      <= 1'b1;
                            frame_cnt <= '0;
                        end
                    end
                end

                // Between preamble and frame, and between frames, the line
                // may idle at 1 for any number of bits.
                S_PRE: begin
                    if (DIN_VALID && !DIN) begin
                        state   <= S_FRAME;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                end

                S_FRAME: begin
                    if (DIN_VALID) begin
                        if (bit_cnt == STOP_IDX) begin
                            stop_bit <= DIN;
                            state    <= S_CHECK;
                        end else begin
                            // Data and parity bits both feed the parity sum.
                            par_acc <= par_acc ^ DIN;
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                        end
                    end
                end

                // Single-cycle decision; independent of DIN_VALID.
                S_CHECK: begin
                    if (frame_ok(par_acc, stop_bit)) begin
                        CFG_WE   <= 1'b1;
                        CFG_ADDR <= frame_cnt;
                        CFG_DATA <= word_sh;
                        if (frame_cnt == LAST_CLB) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + ADDR_W'(1);
                            state     <= S_PRE;
                        end
                    end else begin
                        state <= S_ERRS;
                        BUSY  <= 1'b0;
                        ERR   <= 1'b1;
                    end
                end

                // Re-arm the preamble hunt from a clean idle-line history.
                S_DONE: begin
                    if (START) begin
                        state  <= S_IDLE;
                        DONE   <= 1'b0;
                        pre_sh <= HUNT_INIT;
                    end
                end

                // Terminal until RST; START and further bits are ignored.
                S_ERRS: begin
                    state <= S_ERRS;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
`timescale 1ns/1ps
// Testbench for clb_cfg_loader: directed scenarios with randomized data,
// idle fill and DIN_VALID gaps; expected writes come from a frame-level model.
module tb_clb_cfg_loader;

    localparam int CFG_W = 37;
    localparam int NUM_CLB = 4;
    localparam int ADDR_W = 2;
    localparam logic [36:0] FIXED_WORD = 37'h1_5000_8B038;

    logic              K = 1'b0;
    logic              RST = 1'b1;
    logic              DIN = 1'b1;
    logic              DIN_VALID = 1'b0;
    logic              START = 1'b0;
    logic              CFG_WE;
    logic [ADDR_W-1:0] CFG_ADDR;
    logic [CFG_W-1:0]  CFG_DATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    clb_cfg_loader #(
        .CFG_W  (CFG_W),
        .NUM_CLB(NUM_CLB),
        .ADDR_W (ADDR_W),
        .PRE    (4'b0010)
    ) dut (
        .K        (K),
        .RST      (RST),
        .DIN      (DIN),
        .DIN_VALID(DIN_VALID),
        .START    (START),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_DATA (CFG_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 K = ~K;

    int checks = 0;
    int errors = 0;

    logic [CFG_W-1:0]        frames [NUM_CLB];
    logic [ADDR_W+CFG_W-1:0] exp_q [$];
    logic [ADDR_W+CFG_W-1:0] obs_q [$];
    int                      wide_cnt = 0;
    logic                    prev_we = 1'b0;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge K) begin
        if (CFG_WE === 1'b1) begin
            obs_q.push_back({CFG_ADDR, CFG_DATA});
            if (prev_we === 1'b1) wide_cnt++;
        end
        prev_we = CFG_WE;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        int n = 0;
        if (gaps) begin
            while (n < 3 && $urandom_range(0, 1) == 1) begin
                DIN = 1'($urandom);
                DIN_VALID = 1'b0;
                @(posedge K); #1;
                n++;
            end
        end
        DIN = b;
        DIN_VALID = 1'b1;
        @(posedge K); #1;
        DIN_VALID = 1'b0;
        DIN = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        DIN_VALID = 1'b0;
        DIN = 1'b1;
        repeat (n) begin @(posedge K); #1; end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge K); #1;
        RST = 1'b0;
        idle_cycles(1);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_we"},   CFG_WE,   0);
        chk({pfx, "_addr"}, CFG_ADDR, 0);
        chk({pfx, "_data"}, CFG_DATA, 0);
        chk({pfx, "_busy"}, BUSY,     0);
        chk({pfx, "_done"}, DONE,     0);
        chk({pfx, "_err"},  ERR,      0);
    endtask

    // Sends one 40-bit frame built from the framing rules. When abort_at
    // matches a bit index, RST is pulsed instead of sending that bit.
    task automatic send_frame(input logic [CFG_W-1:0] d, input bit flip_par,
                              input bit bad_stop, input int abort_at,
                              input bit gaps, output bit aborted);
        logic [CFG_W+2:0] fb;
        fb = {1'b0, d, (^d) ^ flip_par, ~bad_stop};
        aborted = 1'b0;
        for (int k = 0; k < CFG_W + 3; k++) begin
            if (k == abort_at) begin
                RST = 1'b1;
                #1;
                check_all_zero("rst_async");
                @(posedge K); #1;
                RST = 1'b0;
                aborted = 1'b1;
                return;
            end
            send_bit(fb[CFG_W+2-k], gaps);
        end
    endtask

    // Full bitstream: preamble, fill, NUM_CLB frames. Expected writes are
    // the good frames before the first bad one.
    task automatic run_stream(input bit gaps, input int bad_par_f, input int bad_stop_f,
                              input int abort_f, output bit aborted);
        logic [3:0] pre = 4'b0010;
        bit failed = 1'b0;
        bit ab;
        bit good;
        logic [ADDR_W-1:0] fa;
        exp_q.delete();
        obs_q.delete();
        wide_cnt = 0;
        aborted = 1'b0;
        repeat (5) send_bit(1'b1, gaps);
        for (int k = 3; k >= 0; k--) send_bit(pre[k], gaps);
        repeat ($urandom_range(1, 3)) send_bit(1'b1, gaps);
        chk("pre_busy", BUSY, 1);
        chk("pre_done", DONE, 0);
        for (int f = 0; f < NUM_CLB; f++) begin
            if (f > 0) repeat ($urandom_range(0, 2)) send_bit(1'b1, gaps);
            send_frame(frames[f], f == bad_par_f, f == bad_stop_f,
                       (f == abort_f) ? 20 : -1, gaps, ab);
            if (ab) begin
                aborted = 1'b1;
                return;
            end
            if (!failed) begin
                fa = f[ADDR_W-1:0];
                good = (f != bad_par_f) && (f != bad_stop_f);
                chk($sformatf("f%0d_stop_we", f), CFG_WE, 0);
                chk($sformatf("f%0d_stop_err", f), ERR, 0);
                chk($sformatf("f%0d_stop_busy", f), BUSY, 1);
                @(posedge K); #1;
                if (good) begin
                    chk($sformatf("f%0d_we", f), CFG_WE, 1);
                    chk($sformatf("f%0d_addr", f), CFG_ADDR, fa);
                    chk($sformatf("f%0d_data", f), CFG_DATA, frames[f]);
                    exp_q.push_back({fa, frames[f]});
                end else begin
                    chk($sformatf("f%0d_err", f), ERR, 1);
                    chk($sformatf("f%0d_err_we", f), CFG_WE, 0);
                    chk($sformatf("f%0d_err_busy", f), BUSY, 0);
                    failed = 1'b1;
                end
            end
        end
        idle_cycles(3);
    endtask

    task automatic end_checks(input string pfx, input logic exp_done, input logic exp_err);
        idle_cycles(2);
        chk({pfx, "_nwrites"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", pfx, i), obs_q[i], exp_q[i]);
        chk({pfx, "_wide"}, wide_cnt, 0);
        chk({pfx, "_done"}, DONE, exp_done);
        chk({pfx, "_err"},  ERR,  exp_err);
        chk({pfx, "_busy"}, BUSY, 0);
    endtask

    task automatic random_frames();
        for (int i = 0; i < NUM_CLB; i++) frames[i] = {5'($urandom), 32'($urandom)};
    endtask

    initial begin
        bit ab;

        // Reset state
        repeat (2) @(posedge K);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        idle_cycles(2);
        check_all_zero("post_reset");

        // 1: four clean frames of the fixed word
        for (int i = 0; i < NUM_CLB; i++) frames[i] = FIXED_WORD;
        run_stream(1'b0, -1, -1, -1, ab);
        end_checks("s1", 1'b1, 1'b0);

        // 2: parity flipped in frame 1
        do_reset();
        run_stream(1'b0, 1, -1, -1, ab);
        end_checks("s2", 1'b0, 1'b1);

        // 3: stop bit 0 in frame 0, then START in ERRS is ignored
        do_reset();
        random_frames();
        run_stream(1'b0, -1, 0, -1, ab);
        end_checks("s3", 1'b0, 1'b1);
        START = 1'b1;
        @(posedge K); #1;
        START = 1'b0;
        idle_cycles(1);
        chk("s3_start_err", ERR, 1);
        chk("s3_start_busy", BUSY, 0);
        chk("s3_start_done", DONE, 0);

        // 4: fixed word with random DIN_VALID gaps
        do_reset();
        for (int i = 0; i < NUM_CLB; i++) frames[i] = FIXED_WORD;
        run_stream(1'b1, -1, -1, -1, ab);
        end_checks("s4", 1'b1, 1'b0);

        // 5: RST at bit 20 of frame 2, then a fresh stream from addr 0
        do_reset();
        random_frames();
        run_stream(1'b0, -1, -1, 2, ab);
        chk("s5_aborted", ab, 1);
        idle_cycles(2);
        chk("s5_nwrites_pre_rst", obs_q.size(), 2);
        check_all_zero("s5_after_rst");
        random_frames();
        run_stream(1'b1, -1, -1, -1, ab);
        end_checks("s5", 1'b1, 1'b0);

        // 6: START from DONE, second bitstream
        START = 1'b1;
        @(posedge K); #1;
        START = 1'b0;
        chk("s6_done_clr", DONE, 0);
        chk("s6_busy", BUSY, 0);
        random_frames();
        run_stream(1'b1, -1, -1, -1, ab);
        end_checks("s6", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
